// File: rtl/register_readback_pkg.sv
// Shared GPIO command-interface constants for the BER log readback path:
// field positions, opcodes, word-select indices and the FSM state type.
package register_readback_pkg;

    localparam int GPIO_W      = 32;
    localparam int OPCODE_W    = 8;
    localparam int LOG_COUNT_W = 64;
    localparam int SNAP_CNT_W  = 16;
    localparam int REQ_BIT     = 23;
    localparam int SEL_LEN     = 4;

    // 0x00-0x02 are owned by the write-side register file.
    localparam logic [7:0] OP_WRITE_0  = 8'h00;
    localparam logic [7:0] OP_WRITE_1  = 8'h01;
    localparam logic [7:0] OP_WRITE_2  = 8'h02;
    localparam logic [7:0] OP_SNAPSHOT = 8'h03;
    localparam logic [7:0] OP_READ     = 8'h04;

    localparam logic [3:0] SEL_ERR_R_LO = 4'd0;
    localparam logic [3:0] SEL_ERR_R_HI = 4'd1;
    localparam logic [3:0] SEL_ERR_I_LO = 4'd2;
    localparam logic [3:0] SEL_ERR_I_HI = 4'd3;
    localparam logic [3:0] SEL_BIT_R_LO = 4'd4;
    localparam logic [3:0] SEL_BIT_R_HI = 4'd5;
    localparam logic [3:0] SEL_BIT_I_LO = 4'd6;
    localparam logic [3:0] SEL_BIT_I_HI = 4'd7;
    localparam logic [3:0] SEL_STATUS   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_LOW
    } state_e;

endpackage

// File: rtl/register_readback_req_edge.sv
// Request-bit edge detector shared with the write-side register file.
// The history register resets high so a req held through reset is not a command.
module register_readback_req_edge (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    output logic rise_o
);

    logic req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 1'b1;
        end else begin
            req_q <= req_i;
        end
    end

    assign rise_o = req_i & ~req_q;

endmodule

// File: rtl/register_readback.sv
// Read side of the GPIO command interface: SNAPSHOT freezes the four BER
// counters into shadows atomically, READ returns one 32-bit shadow word.
module register_readback
    import register_readback_pkg::*;
#(
    parameter int GPIO_LEN      = GPIO_W,
    parameter int OPCODE_LEN    = OPCODE_W,
    parameter int LOG_COUNT_LEN = LOG_COUNT_W,
    parameter int SNAP_CNT_LEN  = SNAP_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [GPIO_LEN-1:0]      gpio_in,
    input  logic [LOG_COUNT_LEN-1:0] error_count_r,
    input  logic [LOG_COUNT_LEN-1:0] error_count_i,
    input  logic [LOG_COUNT_LEN-1:0] bit_count_r,
    input  logic [LOG_COUNT_LEN-1:0] bit_count_i,
    output logic [GPIO_LEN-1:0]      gpio_out
);

    logic                     req;
    logic                     req_rise;
    state_e                   state_q;
    logic [OPCODE_LEN-1:0]    opcode_q;
    logic [SEL_LEN-1:0]       sel_q;
    logic [LOG_COUNT_LEN-1:0] err_r_q;
    logic [LOG_COUNT_LEN-1:0] err_i_q;
    logic [LOG_COUNT_LEN-1:0] bit_r_q;
    logic [LOG_COUNT_LEN-1:0] bit_i_q;
    logic [SNAP_CNT_LEN-1:0]  snap_count_q;
    logic                     snap_valid_q;
    logic [GPIO_LEN-1:0]      gpio_out_q;
    logic [GPIO_LEN-1:0]      read_word_d;
    logic [GPIO_LEN-1:0]      status_word;
    logic                     unused_data;

    assign req         = gpio_in[REQ_BIT];
    assign unused_data = ^gpio_in[REQ_BIT-1:SEL_LEN];

    register_readback_req_edge u_req_edge (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .rise_o (req_rise)
    );

    assign status_word = {snap_count_q, {(GPIO_LEN-SNAP_CNT_LEN-1){1'b0}}, snap_valid_q};

    // Only shadows feed the mux, so hi/lo halves always come from one snapshot.
    always_comb begin
        read_word_d = '0;
        case (sel_q)
            SEL_ERR_R_LO: read_word_d = err_r_q[GPIO_LEN-1:0];
            SEL_ERR_R_HI: read_word_d = err_r_q[LOG_COUNT_LEN-1 -: GPIO_LEN];
            SEL_ERR_I_LO: read_word_d = err_i_q[GPIO_LEN-1:0];
            SEL_ERR_I_HI: read_word_d = err_i_q[LOG_COUNT_LEN-1 -: GPIO_LEN];
            SEL_BIT_R_LO: read_word_d = bit_r_q[GPIO_LEN-1:0];
            SEL_BIT_R_HI: read_word_d = bit_r_q[LOG_COUNT_LEN-1 -: GPIO_LEN];
            SEL_BIT_I_LO: read_word_d = bit_i_q[GPIO_LEN-1:0];
            SEL_BIT_I_HI: read_word_d = bit_i_q[LOG_COUNT_LEN-1 -: GPIO_LEN];
            SEL_STATUS:   read_word_d = status_word;
            default:      read_word_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            opcode_q     <= '0;
            sel_q        <= '0;
            err_r_q      <= '0;
            err_i_q      <= '0;
            bit_r_q      <= '0;
            bit_i_q      <= '0;
            snap_count_q <= '0;
            snap_valid_q <= 1'b0;
            gpio_out_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_rise) begin
                        opcode_q <= gpio_in[GPIO_LEN-1 -: OPCODE_LEN];
                        sel_q    <= gpio_in[SEL_LEN-1:0];
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opcode_q)
                        OP_SNAPSHOT: begin
                            err_r_q      <= error_count_r;
                            err_i_q      <= error_count_i;
                            bit_r_q      <= bit_count_r;
                            bit_i_q      <= bit_count_i;
                            snap_count_q <= snap_count_q + 1'b1;
                            snap_valid_q <= 1'b1;
                        end
                        OP_READ: gpio_out_q <= read_word_d;
                        OP_WRITE_0, OP_WRITE_1, OP_WRITE_2: ;
                        default: ;
                    endcase
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_register_readback.sv
// Scoreboard bench for register_readback: a shadow model predicts every READ
// word, expected words are queued at issue time and popped when gpio_out updates.
module tb_register_readback;
    import register_readback_pkg::*;

    // Short sequence counter so the wrap-around is reachable in a few cycles.
    localparam int SNAP_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [63:0] base [4];
    logic [63:0] inc_cnt = '0;
    logic        incr_en = 1'b0;
    logic [63:0] err_r_w, err_i_w, bit_r_w, bit_i_w;

    logic [63:0]       shadow_m [4];
    logic [SNAP_W-1:0] snap_m;
    logic              valid_m;
    logic [31:0]       last_out;
    logic [31:0]       exp_q [$];
    int                n_checks = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (incr_en) inc_cnt = inc_cnt + 64'd1;
    end

    assign err_r_w = base[0] + inc_cnt;
    assign err_i_w = base[1] + inc_cnt;
    assign bit_r_w = base[2] + inc_cnt;
    assign bit_i_w = base[3] + inc_cnt;

    register_readback #(.SNAP_CNT_LEN(SNAP_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .gpio_in       (gpio_in),
        .error_count_r (err_r_w),
        .error_count_i (err_i_w),
        .bit_count_r   (bit_r_w),
        .bit_count_i   (bit_i_w),
        .gpio_out      (gpio_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: gpio_out=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: gpio_out=%h", tag, got);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [3:0] s);
        logic [31:0] st;
        if (s < 4'd8) begin
            return s[0] ? shadow_m[s[2:1]][63:32] : shadow_m[s[2:1]][31:0];
        end else if (s == 4'd8) begin
            st = '0;
            st[31 -: SNAP_W] = snap_m;
            st[0] = valid_m;
            return st;
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) shadow_m[i] = '0;
        snap_m   = '0;
        valid_m  = 1'b0;
        last_out = '0;
    endtask

    task automatic model_snapshot();
        shadow_m[0] = err_r_w;
        shadow_m[1] = err_i_w;
        shadow_m[2] = bit_r_w;
        shadow_m[3] = bit_i_w;
        snap_m      = snap_m + 1'b1;
        valid_m     = 1'b1;
    endtask

    task automatic set_cnt(input int idx, input logic [63:0] v);
        base[idx] = v - inc_cnt;
    endtask

    // One full handshake: raise req, check latency, hold, drop req, back to IDLE.
    task automatic issue(input logic [7:0] op, input logic [3:0] sel, input int hold);
        @(negedge clk);
        gpio_in = {op, 1'b1, 19'h0, sel};
        @(posedge clk); #1;
        check_eq($sformatf("op%02h sel%0d before action", op, sel), gpio_out, last_out);
        @(negedge clk); #1;
        if (op == OP_SNAPSHOT) model_snapshot();
        else if (op == OP_READ) exp_q.push_back(model_word(sel));
        @(posedge clk); #1;
        if (op == OP_READ) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard empty: gpio_out=%h expected=<none>", gpio_out);
            end else begin
                last_out = exp_q.pop_front();
                check_eq($sformatf("read sel%0d", sel), gpio_out, last_out);
            end
        end else begin
            check_eq($sformatf("op%02h holds gpio_out", op), gpio_out, last_out);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq($sformatf("op%02h req held %0d", op, h), gpio_out, last_out);
        end
        @(negedge clk);
        gpio_in[REQ_BIT] = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) base[i] = '0;
        model_reset();

        // 1: reset with req held high, which must stay ignored afterwards
        reset   = 1'b1;
        gpio_in = {OP_SNAPSHOT, 1'b1, 19'h0, 4'd8};
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("in reset", gpio_out, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        gpio_in[REQ_BIT] = 1'b0;
        @(posedge clk);
        issue(OP_READ, 4'd8, 0);
        check_eq("status after reset", gpio_out, 32'h0);

        // 2: single counter snapshot and both halves
        set_cnt(0, 64'h0123_4567_89AB_CDEF);
        set_cnt(1, 64'h1111_2222_3333_4444);
        set_cnt(2, 64'hDEAD_BEEF_0000_0001);
        set_cnt(3, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(OP_SNAPSHOT, 4'd0, 0);
        issue(OP_READ, 4'd0, 0);
        check_eq("err_r lo const", gpio_out, 32'h89AB_CDEF);
        issue(OP_READ, 4'd1, 0);
        check_eq("err_r hi const", gpio_out, 32'h0123_4567);

        // 3: atomicity with counters moving every cycle
        set_cnt(0, 64'h0000_0000_FFFF_FFF0);
        set_cnt(1, 64'h0000_0001_0000_0000);
        set_cnt(2, 64'h7FFF_FFFF_FFFF_FFF8);
        set_cnt(3, 64'h0000_0000_0000_0000);
        incr_en = 1'b1;
        issue(OP_SNAPSHOT, 4'd0, 0);
        for (int s = 0; s <= 8; s++) issue(OP_READ, 4'(s), 0);
        for (int s = 9; s <= 15; s++) issue(OP_READ, 4'(s), 0);
        incr_en = 1'b0;

        // 4: sequence counter wrap
        do issue(OP_SNAPSHOT, 4'd0, 0); while (snap_m != '0);
        issue(OP_READ, 4'd8, 0);
        check_eq("wrap status const", gpio_out, 32'h0000_0001);

        // 5: handshake rules
        issue(OP_READ, 4'd2, 10);
        issue(OP_SNAPSHOT, 4'd0, 10);
        issue(OP_WRITE_1, 4'd5, 0);
        @(negedge clk);
        gpio_in = {OP_SNAPSHOT, 1'b1, 19'h0, 4'd0};
        @(posedge clk);
        @(negedge clk); #1;
        model_snapshot();
        gpio_in[REQ_BIT] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        gpio_in[REQ_BIT] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        gpio_in[REQ_BIT] = 1'b0;
        @(posedge clk);
        issue(OP_READ, 4'd8, 0);

        // 6: reset during the EXEC cycle of a READ, req still high afterwards
        @(negedge clk);
        gpio_in = {OP_READ, 1'b1, 19'h0, 4'd1};
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("reset mid-op", gpio_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        gpio_in = {OP_SNAPSHOT, 1'b1, 19'h0, 4'd0};
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("post-reset req high", gpio_out, 32'h0);
        end
        @(negedge clk);
        gpio_in[REQ_BIT] = 1'b0;
        @(posedge clk);
        issue(OP_READ, 4'd8, 0);
        issue(OP_READ, 4'd1, 0);
        issue(OP_SNAPSHOT, 4'd0, 0);
        issue(OP_READ, 4'd8, 0);
        issue(OP_READ, 4'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
